// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and keyboard receiver path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        WAIT_IDLE,
        FAIL
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Integer cycle count for a duration in microseconds.
    function automatic int unsigned cyc_count(input int unsigned clk_hz, input int unsigned us);
        return clk_hz / 1_000_000 * us;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a falling-edge pulse on the clock.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic fall
);

    logic clk_m, clk_s0, clk_s1;
    logic dat_m, dat_s0;

    // Lines idle high, so the chain resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_m  <= 1'b1;
            clk_s0 <= 1'b1;
            clk_s1 <= 1'b1;
            dat_m  <= 1'b1;
            dat_s0 <= 1'b1;
        end else begin
            clk_m  <= clk_in;
            clk_s0 <= clk_m;
            clk_s1 <= clk_s0;
            dat_m  <= dat_in;
            dat_s0 <= dat_m;
        end
    end

    assign clk_s = clk_s0;
    assign dat_s = dat_s0;
    assign fall  = clk_s1 & ~clk_s0;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, bit shifting on device
// clock falls, and line-ack check. Pad outputs are open-drain enables (1 = pull low).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned INHIBIT_US   = 100,
    parameter int unsigned START_TMO_US = 15_000,
    parameter int unsigned FRAME_TMO_US = 2_000
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe,
    output logic          busy,
    output logic          tx_done,
    output logic          tx_error,
    output ps2_tx_state_e state_dbg
);

    localparam int unsigned INHIBIT_CYC = cyc_count(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned START_CYC   = cyc_count(CLK_FREQ_HZ, START_TMO_US);
    localparam int unsigned FRAME_CYC   = cyc_count(CLK_FREQ_HZ, FRAME_TMO_US);
    localparam int unsigned MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam int unsigned MAX_CYC     = (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;
    localparam int          TMR_W       = $clog2(MAX_CYC);

    localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYC - 1);
    localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_CYC - 1);
    localparam logic [TMR_W-1:0] FRAME_LAST   = TMR_W'(FRAME_CYC - 1);

    ps2_tx_state_e    state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [3:0]       edge_cnt, edge_n;
    logic [7:0]       d, d_n;
    logic             par, par_n;
    logic             clk_oe_n, dat_oe_n;
    logic             clk_s, dat_s, fall;

    ps2_line_sync u_sync (
        .clk    (CLOCK_50),
        .rst_n  (resetn),
        .clk_in (ps2_clk_in),
        .dat_in (ps2_dat_in),
        .clk_s  (clk_s),
        .dat_s  (dat_s),
        .fall   (fall)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            timer      <= '0;
            edge_cnt   <= '0;
            d          <= '0;
            par        <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            edge_cnt   <= edge_n;
            d          <= d_n;
            par        <= par_n;
            ps2_clk_oe <= clk_oe_n;
            ps2_dat_oe <= dat_oe_n;
        end
    end

    // Handshake: a byte is accepted on any cycle where tx_valid & tx_ready; tx_ready is high
    // only in IDLE, and a tx_valid seen in any other state is dropped, never queued.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        edge_n   = edge_cnt;
        d_n      = d;
        par_n    = par;
        clk_oe_n = ps2_clk_oe;
        dat_oe_n = ps2_dat_oe;
        tx_done  = 1'b0;
        tx_error = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    d_n      = tx_data;
                    par_n    = ~^tx_data;
                    timer_n  = '0;
                    edge_n   = '0;
                    clk_oe_n = 1'b1;
                    dat_oe_n = 1'b0;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer == INHIBIT_LAST) begin
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b1;
                    timer_n  = '0;
                    state_n  = REQ;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            REQ: begin
                if (fall) begin
                    edge_n   = 4'd1;
                    dat_oe_n = ~d[0];
                    timer_n  = '0;
                    state_n  = SHIFT;
                end else if (timer == START_LAST) begin
                    dat_oe_n = 1'b0;
                    state_n  = FAIL;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            SHIFT: begin
                if (timer == FRAME_LAST) begin
                    dat_oe_n = 1'b0;
                    state_n  = FAIL;
                end else begin
                    timer_n = timer + 1'b1;
                    if (fall) begin
                        edge_n = edge_cnt + 4'd1;
                        // edge_cnt is the edge just completed; the new edge carries the next bit.
                        if (edge_cnt <= 4'd7) begin
                            dat_oe_n = ~d[edge_cnt[2:0]];
                        end else if (edge_cnt == 4'd8) begin
                            dat_oe_n = ~par;
                        end else if (edge_cnt == 4'd9) begin
                            dat_oe_n = 1'b0;
                        end else begin
                            dat_oe_n = 1'b0;
                            state_n  = dat_s ? FAIL : WAIT_IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    tx_done = 1'b1;
                    state_n = IDLE;
                end else if (timer == FRAME_LAST) begin
                    state_n = FAIL;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            FAIL: begin
                tx_error = 1'b1;
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                state_n  = IDLE;
            end
            default: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    assign tx_ready  = (state == IDLE);
    assign busy      = ~tx_ready;
    assign state_dbg = state;

endmodule
